// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and frame geometry.
// Used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } uart_state_t;

  localparam int DATA_BITS = 8;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period tick generator. The counter is held at zero while en is low,
// so the first tick lands a full bit period after en rises.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || !en)       cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + CW'(1);
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: serialises one byte per tx_start LSB-first with a
// start bit and STOP_BITS stop bits; drives the intff tx/tx_* signals.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 1000000,
  parameter int BAUD_RATE = 9600,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       tx_done,
  output logic       tx_busy,
  output logic       uclktx,
  output logic [1:0] state_tx,
  output logic [3:0] bit_count,
  output logic [7:0] shifter
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;

  if (CLKS_PER_BIT < 2) begin : g_bad_rate
    $error("uart_tx: CLK_FREQ/BAUD_RATE must be >= 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end

  uart_state_t state;
  logic        tick;

  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk  (clk),
    .rst  (rst),
    .en   (state != IDLE),
    .tick (tick)
  );

  assign uclktx   = tick;
  assign state_tx = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tx        <= 1'b1;
      tx_done   <= 1'b0;
      tx_busy   <= 1'b0;
      bit_count <= '0;
      shifter   <= '0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (tx_start) begin
            shifter   <= tx_data;
            bit_count <= '0;
            tx        <= 1'b0;
            tx_busy   <= 1'b1;
            state     <= START;
          end
        end
        START: begin
          if (tick) begin
            tx    <= shifter[0];
            state <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_count == 4'(DATA_BITS - 1)) begin
              tx        <= 1'b1;
              bit_count <= '0;
              state     <= STOP;
            end else begin
              // shifter[1] is the bit that becomes shifter[0] after this shift
              shifter   <= shifter >> 1;
              tx        <= shifter[1];
              bit_count <= bit_count + 4'd1;
            end
          end
        end
        STOP: begin
          tx <= 1'b1;
          if (tick) begin
            if (bit_count == 4'(STOP_BITS - 1)) begin
              tx_done <= 1'b1;
              tx_busy <= 1'b0;
              state   <= IDLE;
            end else begin
              bit_count <= bit_count + 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
8N1 UART transmitter: the transmit-side counterpart of the existing UART receiver, and the driver for the intff `tx` and `tx_*` signals.
- Accepts one byte per tx_start handshake and serialises it LSB-first on `tx`: start bit, 8 data bits, then STOP_BITS stop bits.
- Generates its own bit-rate enable (uclktx) from clk.
- Exposes state_tx, bit_count and shifter so the intff assertion set can check it.

Parameters:
CLK_FREQ, 1000000, system clock frequency in Hz
BAUD_RATE, 9600, line bit rate in bit/s; CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer divide), must be >= 2 (elaboration-time error otherwise)
STOP_BITS, 1, number of stop bits, 1 or 2 only

Ports:
clk  in  1  system clock; single clock domain
rst  in  1  synchronous, active-high reset
tx_start  in  1  request; sampled only in IDLE
tx_data  in  8  byte to send; captured on the acceptance edge only
tx  out  1  serial line, idle high, registered
tx_done  out  1  one-clk pulse at frame end
tx_busy  out  1  high from acceptance until the tx_done cycle (exclusive)
uclktx  out  1  one-clk bit-period tick
state_tx  out  2  FSM state (observability)
bit_count  out  4  data/stop bit index (observability)
shifter  out  8  data shift register (observability)

Behaviour:
- Reset (sync, highest priority) drives:
  - tx=1, tx_done=0, tx_busy=0, uclktx=0
  - state_tx=IDLE, bit_count=0, shifter=0, divider=0
- Reset mid-frame: the next edge returns to IDLE with tx=1; no tx_done; the truncated frame is abandoned.
- Divider:
  - Held at 0 in IDLE.
  - Otherwise counts 0..CLKS_PER_BIT-1 and wraps.
  - uclktx=1 for exactly the clk where the count equals CLKS_PER_BIT-1.
- States: IDLE=0, START=1, DATA=2, STOP=3.
- IDLE:
  - tx=1.
  - If tx_start=1: shifter<=tx_data, bit_count<=0, tx<=0, tx_busy<=1, go to START.
- START:
  - tx=0.
  - On uclktx: tx<=shifter[0], go to DATA.
- DATA, on each uclktx:
  - If bit_count==7: tx<=1, bit_count<=0, go to STOP.
  - Else: shifter<=shifter>>1, tx<=next bit, bit_count<=bit_count+1.
- STOP:
  - tx=1.
  - On uclktx with bit_count==STOP_BITS-1: go to IDLE, tx_done<=1 (for one clk), tx_busy<=0.
  - Otherwise on uclktx: bit_count<=bit_count+1.
- Timing:
  - tx goes low the clk after acceptance.
  - Each bit lasts exactly CLKS_PER_BIT clks.
  - tx_done is asserted (9+STOP_BITS)*CLKS_PER_BIT clks after the acceptance edge.
- tx_start outside IDLE is ignored: no queuing, no corruption of the frame in flight.
- tx_start held high in IDLE after a frame starts the next frame immediately.
- Back-to-back: a tx_start coinciding with tx_done (state is IDLE that cycle) is accepted, giving zero idle time between the stop bit and the next start bit.
- tx_data changes after acceptance have no effect.

Decomposition:
- Package uart_pkg, shared with the receiver, holds:
  - uart_state_t enum {IDLE=2'b00, START=2'b01, DATA=2'b10, STOP=2'b11}
  - DATA_BITS=8
- Sub-module uart_baud_gen(clk, rst, en, tick):
  - Parameter CLKS_PER_BIT.
  - Counter cleared when en=0; tick drives uclktx.
  - Reusable by the receiver.

Test Plan:
All scenarios use CLK_FREQ=100, BAUD_RATE=10, i.e. CLKS_PER_BIT=10.
1. tx_start with tx_data=0xA5 -> tx sampled mid-bit: 0,1,0,1,0,0,1,0,1,1; tx_done exactly 100 clks after acceptance; tx_busy high 100 clks.
2. Send 0x00, then 0xFF with tx_start asserted in the tx_done cycle -> tx steps 1→0 the next clk with no idle gap; second frame reads 0,1×8,1.
3. Frame 0x81 in progress, pulse tx_start with 0x3C at data bit 4 -> line carries only 0x81; exactly one tx_done.
4. Send 0x55, assert rst during data bit 3 -> next clk: tx=1, state_tx=0, tx_busy=0, no tx_done; subsequent 0x55 frame is correct.
5. STOP_BITS=2, send 0x0F -> tx high 20 clks after the last data bit; tx_done 110 clks after acceptance.
6. Loopback tx→rx with the existing receiver: send 0x5A and 0xC3 -> rx_data matches each byte, one rx_done per frame, intff assertions 1-5 never fail.
